// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage that owns the program counter, reads each
// 16-bit instruction as two big-endian bytes from a byte-wide instruction
// memory, and hands it to decode over a valid/ready handshake. A taken
// branch from execute redirects the PC with priority over everything else.
//
// Optional feature: define IFU_PERF_CNT_EN to build a 16-bit counter of
// accepted instructions on InstrCount; otherwise InstrCount is tied to zero.
//
// Ports:
//   Clock, Reset             clock, asynchronous active-high reset
//   MemAddr, MemReq          byte read request to instruction memory
//   MemAck, MemData          read completion and returned byte
//   Instruction, InstrPC     assembled instruction and its address
//   InstrValid, InstrReady   handshake towards decode
//   BranchTaken, BranchPC,
//   BranchImm                redirect request from execute
//   InstrCount               accepted-instruction count (optional)
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'd10
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] MemAddr,
  output logic        MemReq,
  input  logic        MemAck,
  input  logic [7:0]  MemData,
  output logic [15:0] Instruction,
  output logic [15:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        BranchTaken,
  input  logic [15:0] BranchPC,
  input  logic [7:0]  BranchImm,
  output logic [15:0] InstrCount
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 16;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH_HI = 2'd1,
    S_FETCH_LO = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] hi_byte_q, hi_byte_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic          valid_q, valid_d;

  logic          mem_req_c;
  logic [AW-1:0] mem_addr_c;
  logic [AW-1:0] branch_target_c;
  logic          accept_c;

  // Target = BranchPC + 2 + sign-extended word offset, wrapping mod 2^16.
  assign branch_target_c = BranchPC + AW'(2)
                         + {{7{BranchImm[7]}}, BranchImm, 1'b0};

  assign accept_c = valid_q & InstrReady;

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a taken branch overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (BranchTaken) begin
      state_d = S_FETCH_HI;
    end else begin
      unique case (state_q)
        S_IDLE:     state_d = S_FETCH_HI;
        S_FETCH_HI: if (MemAck) state_d = S_FETCH_LO;
        S_FETCH_LO: if (MemAck) state_d = S_HOLD;
        S_HOLD:     if (InstrReady) state_d = S_FETCH_HI;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Memory request decode from registered state and PC only.
  always_comb begin
    mem_req_c  = 1'b0;
    mem_addr_c = pc_q;
    unique case (state_q)
      S_FETCH_HI: mem_req_c = 1'b1;
      S_FETCH_LO: begin
        mem_req_c  = 1'b1;
        // PC is even, so the low byte address never carries out.
        mem_addr_c = {pc_q[AW-1:1], 1'b1};
      end
      default: ;
    endcase
  end

  assign MemReq  = mem_req_c;
  assign MemAddr = mem_addr_c;

  // Datapath next values: PC, high byte staging, instruction buffer.
  always_comb begin
    pc_d       = pc_q;
    hi_byte_d  = hi_byte_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    if (BranchTaken) begin
      // In-flight byte and any same-cycle MemAck are dropped.
      pc_d    = branch_target_c;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH_HI: if (MemAck) hi_byte_d = MemData;
        S_FETCH_LO: begin
          if (MemAck) begin
            instr_d    = {hi_byte_q, MemData};
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + AW'(2);
          end
        end
        S_HOLD: if (InstrReady) valid_d = 1'b0;
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_q       <= RESET_PC;
      hi_byte_q  <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      hi_byte_q  <= hi_byte_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign Instruction = instr_q;
  assign InstrPC     = instr_pc_q;
  assign InstrValid  = valid_q;

`ifdef IFU_PERF_CNT_EN
  logic [15:0] instr_count_q, instr_count_d;

  // Counts every accepted handshake, including one in a redirect cycle.
  always_comb begin
    instr_count_d = instr_count_q;
    if (accept_c) instr_count_d = instr_count_q + 16'd1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      instr_count_q <= '0;
    end else begin
      instr_count_q <= instr_count_d;
    end
  end

  assign InstrCount = instr_count_q;
`else
  logic unused_accept;
  assign unused_accept = accept_c;
  assign InstrCount    = 16'h0000;
`endif

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that sits directly upstream of the decode/execute datapath. It owns the program counter and reads each 16-bit instruction as two big-endian bytes from the byte-wide instruction memory. It presents the assembled instruction to decode through a valid/ready handshake and applies BEQ-style branch redirects.

## Interface
Parameters:
- `RESET_PC`, default 16'd10: PC value after reset.

Ports:
- `Clock`  in  1  system clock; all state updates on posedge.
- `Reset`  in  1  asynchronous, active-high reset.
- `MemAddr`  out  16  byte address to instruction memory.
- `MemReq`  out  1  a byte read is requested at `MemAddr`.
- `MemAck`  in  1  `MemData` is valid this cycle for the current request.
- `MemData`  in  8  byte returned by instruction memory.
- `Instruction`  out  16  assembled instruction as {byte@PC, byte@PC+1}.
- `InstrPC`  out  16  address of `Instruction`.
- `InstrValid`  out  1  `Instruction`/`InstrPC` hold a valid instruction.
- `InstrReady`  in  1  decode accepts the instruction this cycle.
- `BranchTaken`  in  1  redirect request from execute (Zero & Branch).
- `BranchPC`  in  16  PC of the branching instruction.
- `BranchImm`  in  8  imm[7:0] of the branching instruction.
- `InstrCount`  out  16  count of accepted instructions (see Configuration).

## Operation
- Internal state: `PC` (16 bit), `HiByte` (8 bit), FSM state in {IDLE, FETCH_HI, FETCH_LO, HOLD}.
- IDLE: `MemReq`=0. Always moves to FETCH_HI on the next cycle.
- FETCH_HI: `MemReq`=1, `MemAddr`=PC. On MemAck: HiByte<=MemData, go to FETCH_LO. Without MemAck: hold state and address.
- FETCH_LO: `MemReq`=1, `MemAddr`=PC+1. On MemAck: Instruction<={HiByte,MemData}, InstrPC<=PC, InstrValid<=1, PC<=PC+2, go to HOLD.
- HOLD: `MemReq`=0, `MemAddr`=PC. `Instruction` and `InstrPC` stay stable while InstrValid=1. On InstrReady: InstrValid<=0, go to FETCH_HI.
- Branch target = BranchPC + 2 + {{7{BranchImm[7]}}, BranchImm, 1'b0}, truncated to 16 bits (mod 2^16).
- BranchTaken applies in any state and has priority:
  - PC<=target, state<=FETCH_HI.
  - Any in-flight byte is discarded, and MemAck in the same cycle is ignored.
  - InstrValid<=0.
  - If InstrValid&InstrReady occurs in the same cycle, that handshake still counts as an accepted instruction.
- PC is always even. PC+1 never wraps. PC 16'hFFFE + 2 wraps to 16'h0000.
- Reset values: PC=RESET_PC, state=IDLE, MemReq=0, MemAddr=RESET_PC, Instruction=16'h0000, InstrPC=16'h0000, InstrValid=0, HiByte=0, InstrCount=0.
- Reset asserted mid-operation (any state) returns everything to reset values immediately. The partial fetch is lost.

## Timing
- `MemReq`/`MemAddr` are decoded from registered state/PC and are glitch-free within a cycle.
- MemData is sampled on the posedge where MemReq&MemAck=1. A combinational memory with MemAck tied to 1 is legal.
- Latency with MemAck=1 and InstrReady=1:
  - first InstrValid appears 3 cycles after Reset deassertion (IDLE, FETCH_HI, FETCH_LO);
  - steady throughput is 1 instruction per 3 cycles.
- Each memory wait cycle (MemAck=0) adds one cycle.
- Redirect: MemAddr=target in the cycle after BranchTaken is sampled.
- InstrValid is never deasserted without a handshake, except by BranchTaken or Reset.

## Configuration
- `IFU_PERF_CNT_EN` defined:
  - `InstrCount` is a 16-bit register cleared by Reset.
  - It increments on every cycle with InstrValid&InstrReady, including the handshake in a redirect cycle.
  - It wraps 16'hFFFF -> 16'h0000.
- `IFU_PERF_CNT_EN` undefined: `InstrCount` is tied to 16'h0000 and no counter logic is present.

## Test plan
- Reset release; mem[10]=8'h91, mem[11]=8'h05; MemAck=1, InstrReady=1 -> MemAddr 10 then 11; Instruction=16'h9105, InstrPC=10, InstrValid=1; next MemAddr=12.
- InstrReady=0 for 5 cycles in HOLD -> Instruction, InstrPC and InstrValid stable; MemReq=0. Then InstrReady=1 for one cycle -> InstrValid=0, fetch resumes at PC+2.
- MemAck=0 for 2 cycles in FETCH_HI at PC=12 -> MemAddr held at 12, MemReq=1, no state advance; instruction delivered 2 cycles late.
- BranchTaken during FETCH_LO with BranchPC=16'h0010, BranchImm=8'hFC, MemAck=1 -> byte discarded, no InstrValid; next MemAddr=16'h000A.
- BranchPC=16'hFFFC, BranchImm=8'h00 -> fetch at 16'hFFFE/16'hFFFF, InstrPC=16'hFFFE; next fetch MemAddr=16'h0000. Reset asserted in FETCH_LO -> all outputs at reset values immediately; restart at 10.
- With IFU_PERF_CNT_EN: three handshakes -> InstrCount=3; preload to 16'hFFFF plus one handshake -> InstrCount=0. Without the macro: InstrCount=0 throughout.
